// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial add sequencer: FSM encoding and slice width.
package adder_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

endpackage

// File: rtl/adder_seq_ctrl_nibble_add.sv
// 4-bit ripple slice shared by both requesters; purely combinational.
module nibble_add
   import adder_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
   end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Round-robin nibble-serial add sequencer for two requesters.
// Optional subtract support is compiled in with ADDER_SEQ_SUB_EN.
module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_i,
   input  logic [WIDTH-1:0] src1_0_i,
   input  logic [WIDTH-1:0] src2_0_i,
   input  logic [WIDTH-1:0] src1_1_i,
   input  logic [WIDTH-1:0] src2_1_i,
`ifdef ADDER_SEQ_SUB_EN
   input  logic [1:0]       sub_i,
`endif
   output logic [1:0]       ack_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             id_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic [1:0]       dbg_state_o
);

   localparam int NIB   = WIDTH / SLICE_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   // Handshake: req_i[k] is a level held until ack_o[k] pulses for one cycle;
   // the requester drops it by the following edge, and req_i is only sampled in IDLE.

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               c_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ptr_q;
   logic               grant_any, grant_id, last_step, sub_sel;
   logic [WIDTH-1:0]   src1_sel, src2_sel;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_c;

   assign dbg_state_o = state_q;
   assign last_step   = (cnt_q == CNT_W'(NIB - 1));

`ifdef ADDER_SEQ_SUB_EN
   assign sub_sel = sub_i[grant_id];
`else
   assign sub_sel = 1'b0;
`endif

   nibble_add u_slice (
      .a    (a_q[SLICE_W-1:0]),
      .b    (b_q[SLICE_W-1:0]),
      .cin  (c_q),
      .s    (slice_s),
      .cout (slice_c)
   );

   // A lone request wins outright; the pointer only breaks ties.
   always_comb begin
      grant_any = |req_i;
      grant_id  = ptr_q;
      if (req_i == 2'b01) grant_id = 1'b0;
      else if (req_i == 2'b10) grant_id = 1'b1;
      src1_sel = grant_id ? src1_1_i : src1_0_i;
      src2_sel = grant_id ? src2_1_i : src2_0_i;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_d = RUN;
         RUN:     if (last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         ack_o   <= 2'b00;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         id_o    <= 1'b0;
         sum_o   <= '0;
         cout_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_o   <= 2'b00;
         done_o  <= 1'b0;
         busy_o  <= (state_d != IDLE);
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  a_q   <= src1_sel;
                  b_q   <= sub_sel ? ~src2_sel : src2_sel;
                  c_q   <= sub_sel;
                  cnt_q <= '0;
                  id_o  <= grant_id;
                  ptr_q <= ~grant_id;
                  ack_o <= grant_id ? 2'b10 : 2'b01;
               end
            end
            RUN: begin
               // Result nibbles enter at the top so the LSB nibble lands at [3:0] after NIB steps.
               a_q   <= a_q >> SLICE_W;
               b_q   <= b_q >> SLICE_W;
               c_q   <= slice_c;
               sum_o <= {slice_s, sum_o[WIDTH-1:SLICE_W]};
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_step) begin
                  done_o <= 1'b1;
                  cout_o <= slice_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: random and directed operations checked against
// an arithmetic reference model; subtract cases run when ADDER_SEQ_SUB_EN is defined.
module tb_adder_seq_ctrl;

   localparam int WIDTH = 32;
   localparam int NIB   = WIDTH / 4;
   localparam int EW    = WIDTH + 2;
`ifdef ADDER_SEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       req = 2'b00;
   logic [WIDTH-1:0] s10 = '0, s20 = '0, s11 = '0, s21 = '0;
   logic [1:0]       sub = 2'b00;
   logic [1:0]       ack;
   logic             busy, done, id, cout;
   logic [WIDTH-1:0] sum;
   logic [1:0]       dbg_state;

   logic [EW-1:0] exp_q[$];
   int            lat_q[$];
   int            cyc = 0;
   int            n_vec = 0;
   int            n_miss = 0;
   int            last_ack_cyc = -1;
   bit            ptr_m = 1'b0;

   adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .src1_0_i    (s10),
      .src2_0_i    (s20),
      .src1_1_i    (s11),
      .src2_1_i    (s21),
`ifdef ADDER_SEQ_SUB_EN
      .sub_i       (sub),
`endif
      .ack_o       (ack),
      .busy_o      (busy),
      .done_o      (done),
      .id_o        (id),
      .sum_o       (sum),
      .cout_o      (cout),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer add, or subtract with "no borrow" carry.
   function automatic logic [EW-1:0] model(input bit k, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input bit s);
      logic [WIDTH:0] r;
      if (s) r = {(a >= b), a - b};
      else   r = {1'b0, a} + {1'b0, b};
      return {k, r};
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      check("rst_outputs", {ack, busy, done, id, cout, dbg_state}, 64'd0);
      check("rst_sum", sum, 64'd0);
      rst = 1'b0;
      ptr_m = 1'b0;
   endtask

   task automatic wait_ack(input bit k);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ack != 2'b00) got = 1'b1;
      end
      if (!got) begin
         n_vec++;
         n_miss++;
         $display("FAIL ack_timeout: got no ack, expected ack for requester %0d", k);
         req[k] = 1'b0;
         return;
      end
      check("ack_id", ack, k ? 64'd2 : 64'd1);
      check("busy_on_ack", busy, 64'd1);
      if (last_ack_cyc >= 0) check("grant_spacing", cyc - last_ack_cyc, NIB + 2);
      last_ack_cyc = cyc;
      lat_q.push_back(cyc);
      req[k] = 1'b0;
      // Operands are don't-care after capture: scramble them.
      if (k) begin s11 = $urandom; s21 = $urandom; end
      else   begin s10 = $urandom; s20 = $urandom; end
      @(negedge clk);
      check("ack_pulse", ack, 64'd0);
   endtask

   task automatic run_round(input logic [1:0] r, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                            input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                            input logic [1:0] sb, input bit cont);
      logic [1:0] pending;
      bit         k;
      @(negedge clk);
      if (!cont) last_ack_cyc = -1;
      s10 = a0; s20 = b0; s11 = a1; s21 = b1; sub = sb;
      req = r;
      pending = r;
      while (pending != 2'b00) begin
         k = (pending == 2'b11) ? ptr_m : pending[1];
         ptr_m = ~k;
         exp_q.push_back(model(k, k ? a1 : a0, k ? b1 : b0, sb[k] & SUB_EN));
         pending[k] = 1'b0;
         wait_ack(k);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // scoreboard monitor
   initial begin : monitor
      logic [EW-1:0] e;
      int            t0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_done: got id=%0d sum=0x%0h cout=%0d, expected no done", id, sum, cout);
            end else begin
               e = exp_q.pop_front();
               check("result", {id, cout, sum}, e);
               if (lat_q.size() != 0) begin
                  t0 = lat_q.pop_front();
                  check("done_latency", cyc - t0, NIB);
               end
            end
         end
      end
   end

   // stimulus
   initial begin
      logic [1:0] r;
      repeat (2) @(negedge clk);
      check("init_outputs", {ack, busy, done, id, cout, dbg_state}, 64'd0);
      check("init_sum", sum, 64'd0);
      rst = 1'b0;

      // carry ripple across all nibbles
      run_round(2'b01, 32'h0000_0001, 32'hFFFF_FFFF, '0, '0, 2'b00, 1'b0);
      drain();

      // simultaneous requests after reset: requester 0 first, then 1
      reset_dut();
      run_round(2'b11, 32'h1234_5678, 32'h1111_1111, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0);

      // lone requester 1 re-raised right after each ack, pointer favours 0
      run_round(2'b10, '0, '0, 32'hDEAD_BEEF, 32'h0000_1111, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++)
         run_round(2'b10, '0, '0, $urandom, $urandom, 2'b00, 1'b1);
      drain();

      // reset at RUN step 4 with the request held through reset
      @(negedge clk);
      s10 = 32'hAAAA_0000; s20 = 32'h0000_5555; req = 2'b01;
      exp_q.push_back(model(1'b0, s10, s20, 1'b0));
      last_ack_cyc = -1;
      wait_ack(1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      req = 2'b01;
      s10 = 32'h0F0F_0F0F; s20 = 32'h0101_0101;
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      check("midop_rst_outputs", {ack, busy, done, id, cout, dbg_state}, 64'd0);
      check("midop_rst_sum", sum, 64'd0);
      rst = 1'b0;
      ptr_m = 1'b0;
      exp_q.push_back(model(1'b0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0));
      ptr_m = 1'b1;
      last_ack_cyc = -1;
      wait_ack(1'b0);
      drain();

`ifdef ADDER_SEQ_SUB_EN
      run_round(2'b01, 32'd5, 32'd7, '0, '0, 2'b01, 1'b0);
      run_round(2'b01, 32'd7, 32'd5, '0, '0, 2'b01, 1'b0);
      drain();
`endif

      // randomized mix of request patterns and operands
      for (int i = 0; i < 40; i++) begin
         r = 2'($urandom_range(1, 3));
         run_round(r, $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
